// File: rtl/regs_sb_if.sv
// rtl/regs_sb_if.sv - decode/writeback bundle for the regs_sb register file
// Master is the pipeline side (decoder and writeback), slave is the register file.
interface regs_sb_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic                  w;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] data1_q;
  logic [DATA_WIDTH-1:0] data2_q;
  logic                  claim;
  logic [ADDR_WIDTH-1:0] claim_addr;
  logic                  busy1;
  logic                  busy2;
  logic                  claim_err;
  logic [ADDR_WIDTH:0]   pend_cnt;

  modport master (
    output w, waddr, wdata, raddr1, raddr2, claim, claim_addr,
    input  data1_q, data2_q, busy1, busy2, claim_err, pend_cnt
  );

  modport slave (
    input  w, waddr, wdata, raddr1, raddr2, claim, claim_addr,
    output data1_q, data2_q, busy1, busy2, claim_err, pend_cnt
  );
endinterface

// File: rtl/regs_sb.sv
// rtl/regs_sb.sv - register file with two async read ports, one write port and pending scoreboard
// Optional hardwired-zero r0 and write-to-read bypass; scoreboard lets decode stall on owed results.
module regs_sb #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter bit ZERO_REG   = 1'b0,
  parameter bit BYPASS     = 1'b1
) (
  input logic      clk,
  input logic      reset,
  regs_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] gpr [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic [DEPTH-1:0]      pending_next;
  logic [ADDR_WIDTH:0]   pend_cnt_r;
  logic [ADDR_WIDTH:0]   pend_cnt_next;
  logic                  claim_err_r;
  logic                  claim_err_next;
  logic                  wr_en;
  logic                  claim_en;

  // Writes and claims aimed at a hardwired r0 are dropped before they touch any state.
  always_comb begin
    wr_en    = bus.w && !(ZERO_REG && (bus.waddr == '0));
    claim_en = bus.claim && !(ZERO_REG && (bus.claim_addr == '0));
  end

  // Claim is applied after the write clear so a same-cycle new producer keeps the register pending.
  always_comb begin
    pending_next = pending;
    if (wr_en) begin
      pending_next[bus.waddr] = 1'b0;
    end
    if (claim_en) begin
      pending_next[bus.claim_addr] = 1'b1;
    end
  end

  always_comb begin
    claim_err_next = claim_en && pending[bus.claim_addr]
                     && !(wr_en && (bus.waddr == bus.claim_addr));
  end

  always_comb begin
    pend_cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_next = pend_cnt_next + {{ADDR_WIDTH{1'b0}}, pending_next[i]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        gpr[i] <= '0;
      end
    end else if (wr_en) begin
      gpr[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending     <= '0;
      pend_cnt_r  <= '0;
      claim_err_r <= 1'b0;
    end else begin
      pending     <= pending_next;
      pend_cnt_r  <= pend_cnt_next;
      claim_err_r <= claim_err_next;
    end
  end

  // Read port 1: zero register, then same-cycle forward, then array.
  always_comb begin
    bus.data1_q = gpr[bus.raddr1];
    bus.busy1   = pending[bus.raddr1];
    if (BYPASS && wr_en && (bus.waddr == bus.raddr1)) begin
      bus.data1_q = bus.wdata;
      if (!(claim_en && (bus.claim_addr == bus.raddr1))) begin
        bus.busy1 = 1'b0;
      end
    end
    if (ZERO_REG && (bus.raddr1 == '0)) begin
      bus.data1_q = '0;
      bus.busy1   = 1'b0;
    end
  end

  always_comb begin
    bus.data2_q = gpr[bus.raddr2];
    bus.busy2   = pending[bus.raddr2];
    if (BYPASS && wr_en && (bus.waddr == bus.raddr2)) begin
      bus.data2_q = bus.wdata;
      if (!(claim_en && (bus.claim_addr == bus.raddr2))) begin
        bus.busy2 = 1'b0;
      end
    end
    if (ZERO_REG && (bus.raddr2 == '0)) begin
      bus.data2_q = '0;
      bus.busy2   = 1'b0;
    end
  end

  assign bus.claim_err = claim_err_r;
  assign bus.pend_cnt  = pend_cnt_r;
endmodule

// File: tb/tb_regs_sb.sv
// tb/tb_regs_sb.sv - directed bench for regs_sb in three parameter configurations
// a: bypass, no zero reg; b: no bypass; c: bypass with hardwired zero register.
module tb_regs_sb;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  regs_sb_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus_a ();
  regs_sb_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus_b ();
  regs_sb_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus_c ();

  regs_sb #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
  regs_sb #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (.clk(clk), .reset(reset), .bus(bus_b));
  regs_sb #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_c (.clk(clk), .reset(reset), .bus(bus_c));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic idle_all();
    bus_a.w = 0; bus_a.waddr = 0; bus_a.wdata = 0; bus_a.raddr1 = 0; bus_a.raddr2 = 0; bus_a.claim = 0; bus_a.claim_addr = 0;
    bus_b.w = 0; bus_b.waddr = 0; bus_b.wdata = 0; bus_b.raddr1 = 0; bus_b.raddr2 = 0; bus_b.claim = 0; bus_b.claim_addr = 0;
    bus_c.w = 0; bus_c.waddr = 0; bus_c.wdata = 0; bus_c.raddr1 = 0; bus_c.raddr2 = 0; bus_c.claim = 0; bus_c.claim_addr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] a;
    reset = 0;
    repeat (2) step();
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      bus_a.raddr1 = a; bus_a.raddr2 = a;
      #1;
      checks++; if (bus_a.data1_q !== 8'h00) begin failures++; $display("FAIL reset_data1 addr=%0d got=%h exp=00", i, bus_a.data1_q); end
      checks++; if (bus_a.data2_q !== 8'h00) begin failures++; $display("FAIL reset_data2 addr=%0d got=%h exp=00", i, bus_a.data2_q); end
      checks++; if ({bus_a.busy1, bus_a.busy2} !== 2'b00) begin failures++; $display("FAIL reset_busy addr=%0d got=%b exp=00", i, {bus_a.busy1, bus_a.busy2}); end
    end
    checks++; if (bus_a.pend_cnt !== 3'd0) begin failures++; $display("FAIL reset_pend_cnt got=%0d exp=0", bus_a.pend_cnt); end
    checks++; if (bus_a.claim_err !== 1'b0) begin failures++; $display("FAIL reset_claim_err got=%b exp=0", bus_a.claim_err); end
    reset = 1;
    idle_all();
    step();
  endtask

  task automatic test_bypass();
    bus_a.w = 1; bus_a.waddr = 2; bus_a.wdata = 8'hA5; bus_a.raddr1 = 2;
    bus_b.w = 1; bus_b.waddr = 2; bus_b.wdata = 8'hA5; bus_b.raddr1 = 2;
    #1;
    checks++; if (bus_a.data1_q !== 8'hA5) begin failures++; $display("FAIL bypass_same_cycle got=%h exp=a5", bus_a.data1_q); end
    checks++; if (bus_b.data1_q !== 8'h00) begin failures++; $display("FAIL nobypass_same_cycle got=%h exp=00", bus_b.data1_q); end
    step();
    bus_a.w = 0; bus_b.w = 0;
    #1;
    checks++; if (bus_a.data1_q !== 8'hA5) begin failures++; $display("FAIL bypass_next_cycle got=%h exp=a5", bus_a.data1_q); end
    checks++; if (bus_b.data1_q !== 8'hA5) begin failures++; $display("FAIL nobypass_next_cycle got=%h exp=a5", bus_b.data1_q); end
    bus_a.raddr1 = 2; bus_a.raddr2 = 2;
    #1;
    checks++; if (bus_a.data2_q !== 8'hA5) begin failures++; $display("FAIL dual_port_same_reg got=%h exp=a5", bus_a.data2_q); end
    idle_all();
  endtask

  task automatic test_zero_reg();
    bus_a.w = 1; bus_a.waddr = 0; bus_a.wdata = 8'h3C; bus_a.claim = 1; bus_a.claim_addr = 0; bus_a.raddr1 = 0;
    bus_c.w = 1; bus_c.waddr = 0; bus_c.wdata = 8'h3C; bus_c.claim = 1; bus_c.claim_addr = 0; bus_c.raddr1 = 0;
    #1;
    checks++; if (bus_c.data1_q !== 8'h00) begin failures++; $display("FAIL zero_bypass_blocked got=%h exp=00", bus_c.data1_q); end
    checks++; if (bus_a.data1_q !== 8'h3C) begin failures++; $display("FAIL nozero_bypass got=%h exp=3c", bus_a.data1_q); end
    step();
    idle_all();
    #1;
    checks++; if (bus_c.data1_q !== 8'h00) begin failures++; $display("FAIL zero_read got=%h exp=00", bus_c.data1_q); end
    checks++; if (bus_c.busy1 !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", bus_c.busy1); end
    checks++; if (bus_c.pend_cnt !== 3'd0) begin failures++; $display("FAIL zero_pend_cnt got=%0d exp=0", bus_c.pend_cnt); end
    checks++; if (bus_a.data1_q !== 8'h3C) begin failures++; $display("FAIL nozero_read got=%h exp=3c", bus_a.data1_q); end
    checks++; if (bus_a.busy1 !== 1'b1) begin failures++; $display("FAIL nozero_busy got=%b exp=1", bus_a.busy1); end
    checks++; if (bus_a.pend_cnt !== 3'd1) begin failures++; $display("FAIL nozero_pend_cnt got=%0d exp=1", bus_a.pend_cnt); end
    bus_c.claim = 1; bus_c.claim_addr = 0;
    bus_a.w = 1; bus_a.waddr = 0; bus_a.wdata = 8'h3C; bus_a.raddr1 = 0;
    #1;
    checks++; if (bus_a.busy1 !== 1'b0) begin failures++; $display("FAIL busy_suppressed_on_write got=%b exp=0", bus_a.busy1); end
    step();
    idle_all();
    #1;
    checks++; if (bus_c.claim_err !== 1'b0) begin failures++; $display("FAIL zero_reclaim_err got=%b exp=0", bus_c.claim_err); end
    checks++; if (bus_a.pend_cnt !== 3'd0) begin failures++; $display("FAIL nozero_cleared got=%0d exp=0", bus_a.pend_cnt); end
  endtask

  task automatic test_scoreboard();
    bus_a.claim = 1; bus_a.claim_addr = 3;
    bus_b.claim = 1; bus_b.claim_addr = 3;
    step();
    idle_all();
    bus_a.raddr2 = 3; bus_b.raddr2 = 3;
    #1;
    checks++; if (bus_a.busy2 !== 1'b1) begin failures++; $display("FAIL claim_busy2 got=%b exp=1", bus_a.busy2); end
    checks++; if (bus_a.pend_cnt !== 3'd1) begin failures++; $display("FAIL claim_pend_cnt got=%0d exp=1", bus_a.pend_cnt); end
    checks++; if (bus_b.busy2 !== 1'b1) begin failures++; $display("FAIL claim_busy2_b got=%b exp=1", bus_b.busy2); end
    bus_a.w = 1; bus_a.waddr = 3; bus_a.wdata = 8'h11;
    bus_b.w = 1; bus_b.waddr = 3; bus_b.wdata = 8'h11;
    #1;
    checks++; if (bus_a.busy2 !== 1'b0) begin failures++; $display("FAIL write_cycle_busy2 got=%b exp=0", bus_a.busy2); end
    checks++; if (bus_a.data2_q !== 8'h11) begin failures++; $display("FAIL write_cycle_data2 got=%h exp=11", bus_a.data2_q); end
    checks++; if (bus_b.busy2 !== 1'b1) begin failures++; $display("FAIL nobypass_write_busy2 got=%b exp=1", bus_b.busy2); end
    checks++; if (bus_b.data2_q !== 8'h00) begin failures++; $display("FAIL nobypass_write_data2 got=%h exp=00", bus_b.data2_q); end
    step();
    bus_a.w = 0; bus_b.w = 0;
    #1;
    checks++; if (bus_a.pend_cnt !== 3'd0) begin failures++; $display("FAIL write_clears_pend got=%0d exp=0", bus_a.pend_cnt); end
    checks++; if (bus_b.busy2 !== 1'b0) begin failures++; $display("FAIL nobypass_after_busy2 got=%b exp=0", bus_b.busy2); end
    checks++; if (bus_b.data2_q !== 8'h11) begin failures++; $display("FAIL nobypass_after_data2 got=%h exp=11", bus_b.data2_q); end
    idle_all();
  endtask

  task automatic test_simultaneous();
    bus_a.w = 1; bus_a.waddr = 1; bus_a.wdata = 8'h77; bus_a.claim = 1; bus_a.claim_addr = 1; bus_a.raddr1 = 1;
    #1;
    checks++; if (bus_a.data1_q !== 8'h77) begin failures++; $display("FAIL wc_bypass_data got=%h exp=77", bus_a.data1_q); end
    step();
    bus_a.w = 0;
    checks++; if (bus_a.pend_cnt !== 3'd1) begin failures++; $display("FAIL wc_pend_kept got=%0d exp=1", bus_a.pend_cnt); end
    checks++; if (bus_a.claim_err !== 1'b0) begin failures++; $display("FAIL wc_no_err got=%b exp=0", bus_a.claim_err); end
    checks++; if (bus_a.busy1 !== 1'b1) begin failures++; $display("FAIL wc_busy1 got=%b exp=1", bus_a.busy1); end
    step();
    bus_a.claim = 0;
    checks++; if (bus_a.claim_err !== 1'b1) begin failures++; $display("FAIL reclaim_err got=%b exp=1", bus_a.claim_err); end
    checks++; if (bus_a.pend_cnt !== 3'd1) begin failures++; $display("FAIL reclaim_pend_cnt got=%0d exp=1", bus_a.pend_cnt); end
    step();
    checks++; if (bus_a.claim_err !== 1'b0) begin failures++; $display("FAIL reclaim_err_pulse got=%b exp=0", bus_a.claim_err); end
    bus_a.w = 1; bus_a.waddr = 1; bus_a.wdata = 8'h78; bus_a.claim = 1; bus_a.claim_addr = 1;
    #1;
    checks++; if (bus_a.busy1 !== 1'b1) begin failures++; $display("FAIL wc_busy_not_suppressed got=%b exp=1", bus_a.busy1); end
    step();
    bus_a.claim = 0;
    checks++; if (bus_a.claim_err !== 1'b0) begin failures++; $display("FAIL wc_pending_no_err got=%b exp=0", bus_a.claim_err); end
    step();
    bus_a.w = 0;
    checks++; if (bus_a.pend_cnt !== 3'd0) begin failures++; $display("FAIL wc_cleanup got=%0d exp=0", bus_a.pend_cnt); end
    idle_all();
  endtask

  task automatic test_full();
    logic [7:0] e1;
    logic [7:0] e2;
    for (int i = 0; i < 4; i++) begin
      bus_a.claim = 1; bus_a.claim_addr = 2'(i);
      step();
      bus_a.claim = 0;
      checks++; if (bus_a.pend_cnt !== 3'(i + 1)) begin failures++; $display("FAIL full_claim_cnt step=%0d got=%0d exp=%0d", i, bus_a.pend_cnt, i + 1); end
      checks++; if (bus_a.claim_err !== 1'b0) begin failures++; $display("FAIL full_claim_err step=%0d got=%b exp=0", i, bus_a.claim_err); end
    end
    for (int i = 0; i < 4; i++) begin
      bus_a.w = 1; bus_a.waddr = 2'(i); bus_a.wdata = 8'(8'h40 + i);
      step();
      bus_a.w = 0;
      checks++; if (bus_a.pend_cnt !== 3'(3 - i)) begin failures++; $display("FAIL full_write_cnt step=%0d got=%0d exp=%0d", i, bus_a.pend_cnt, 3 - i); end
    end
    for (int i = 0; i < 4; i++) begin
      bus_a.raddr1 = 2'(i); bus_a.raddr2 = 2'(3 - i);
      e1 = 8'(8'h40 + i); e2 = 8'(8'h43 - i);
      #1;
      checks++; if (bus_a.data1_q !== e1) begin failures++; $display("FAIL full_read1 addr=%0d got=%h exp=%h", i, bus_a.data1_q, e1); end
      checks++; if (bus_a.data2_q !== e2) begin failures++; $display("FAIL full_read2 addr=%0d got=%h exp=%h", 3 - i, bus_a.data2_q, e2); end
    end
    idle_all();
  endtask

  task automatic test_reset_mid();
    bus_a.claim = 1; bus_a.claim_addr = 1;
    step();
    bus_a.claim = 0; bus_a.raddr1 = 1;
    #1;
    checks++; if ({bus_a.busy1, bus_a.pend_cnt} !== {1'b1, 3'd1}) begin failures++; $display("FAIL mid_pre_reset got=%b/%0d exp=1/1", bus_a.busy1, bus_a.pend_cnt); end
    #1;
    reset = 0;
    #1;
    checks++; if (bus_a.pend_cnt !== 3'd0) begin failures++; $display("FAIL mid_reset_pend_cnt got=%0d exp=0", bus_a.pend_cnt); end
    checks++; if (bus_a.busy1 !== 1'b0) begin failures++; $display("FAIL mid_reset_busy1 got=%b exp=0", bus_a.busy1); end
    checks++; if (bus_a.data1_q !== 8'h00) begin failures++; $display("FAIL mid_reset_data1 got=%h exp=00", bus_a.data1_q); end
    reset = 1;
    idle_all();
    step();
  endtask

  initial begin
    clk = 0;
    reset = 0;
    checks = 0;
    failures = 0;
    idle_all();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_simultaneous();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
